intersection_sequencer: RTL and testbench
=========================================

# intersection_sequencer

Two-road intersection controller. Main road (NS) rests in green; side road (EW) is served on demand. The block sequences both signal heads through green, yellow and all-red clearance phases, timed in `tick` units from a shared timebase strobe. It sits above the per-head lamp logic and drives six one-hot lamp outputs plus a phase code for status and debug.

## Interface
- `MIN_GREEN`, default 8: minimum NS green dwell, in ticks (≥1).
- `EW_GREEN`, default 4: fixed EW green dwell, in ticks (≥1).
- `YELLOW`, default 2: yellow dwell for either road, in ticks (≥1).
- `ALL_RED`, default 1: all-red clearance dwell, in ticks (≥1).
- `CNT_W`, default 4: dwell counter width; must hold max(all durations)−1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle timebase strobe; counters advance only when high.
- `ew_req` in 1: side-road vehicle request, level or pulse.
- `ped_req` in 1: pedestrian button. Used only with `PED_WALK_EN`.
- `ns_red`, `ns_yellow`, `ns_green` out 1 each: NS head, one-hot.
- `ew_red`, `ew_yellow`, `ew_green` out 1 each: EW head, one-hot.
- `walk` out 1: pedestrian walk indication.
- `phase` out 3: current state code.

## Operation
- States and codes: NS_GREEN=0, NS_YELLOW=1, ALL_RED_1=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED_2=5. Codes 6 and 7 are illegal and go to ALL_RED_2 on the next edge.
- Cycle order: NS_GREEN → NS_YELLOW → ALL_RED_1 → EW_GREEN → EW_YELLOW → ALL_RED_2 → NS_GREEN.
- Dwell counter `cnt` (CNT_W bits):
  - Cleared to 0 on every state change.
  - Increments on `tick`.
  - Saturates at duration−1.
- Exit rule: a timed state exits on the edge where `tick`=1 and `cnt`=duration−1. Each state therefore lasts exactly "duration" ticks.
- NS_GREEN exit additionally requires `pending`=1. With no request, NS stays green indefinitely with `cnt` saturated. A request arriving later exits on the next `tick`.
- Request latch: `pending_next = (pending | ew_req) & ~enter_ew_green`.
  - `ew_req` is masked while in EW_GREEN.
  - Requests during EW_YELLOW or ALL_RED_2 are retained, so EW is served again after the next NS minimum green.
  - Simultaneous set and enter-EW_GREEN: clear wins.
- Lamp decode is combinational from the state register:
  - NS_GREEN: ns_green + ew_red.
  - NS_YELLOW: ns_yellow + ew_red.
  - ALL_RED_1 and ALL_RED_2: both red.
  - EW_GREEN: ew_green + ns_red.
  - EW_YELLOW: ew_yellow + ns_red.
- Invariant: never green or yellow on both roads at once. Exactly one lamp is lit per head.

## Timing
- Reset values: state=ALL_RED_2, cnt=0, pending=0, phase=5, ns_red=ew_red=1, all other lamps 0, walk=0.
- Reset mid-sequence returns to ALL_RED_2 immediately (asynchronous) and discards any pending request.
- Request-to-lamp latency:
  - `ew_req` is sampled at the edge ending the cycle in which it is high.
  - Outputs change in the cycle after the transition edge (zero added decode latency).
- A `tick` coincident with a state change is consumed by the exit. It does not advance the new state's counter.
- With `tick` tied high, dwell in cycles equals the duration parameter.

## Configuration
- `PED_WALK_EN` defined:
  - `ped_req` ORs into the request latch, with the same masking and clear rules as `ew_req`.
  - `walk`=1 exactly while in EW_GREEN, and is forced 0 by reset.
- `PED_WALK_EN` undefined:
  - `ped_req` is ignored.
  - `walk` is tied 0.
  - No added state.

## Test plan
- Reset, `tick`=1, no requests, defaults → phase 5 for 1 cycle, then phase 0 held for 50 cycles with ns_green=1, ew_red=1.
- Reset, `tick`=1, `ew_req` pulsed 1 cycle at cycle 2 → phase 0 ×8, then 1 ×2, 2 ×1, 3 ×4, 4 ×2, 5 ×1, then 0. `pending` clears on entry to 3.
- `tick` every 4th cycle, `ew_req` held → each state lasts duration×4 cycles. Lamps are never green or yellow on both heads.
- `ew_req` pulsed during EW_YELLOW → returns to NS_GREEN for exactly 8 ticks, then re-serves EW. A pulse during EW_GREEN alone causes no re-serve.
- `reset` asserted mid-EW_GREEN, async between edges → outputs immediately both red, phase=5, walk=0. Normal sequence resumes after release.
- `PED_WALK_EN` build, `ped_req` pulse only → same sequence as scenario 2, walk=1 for exactly the 4 EW_GREEN cycles. In the non-`PED_WALK_EN` build the same stimulus keeps phase 0 and walk=0.

Source files
------------

// File: rtl/intersection_sequencer_if.sv
// intersection_sequencer_if: timebase/request inputs and lamp/status outputs of the intersection sequencer
interface intersection_sequencer_if;
  logic tick, ew_req, ped_req;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic [2:0] phase;
  modport master (
    output tick, ew_req, ped_req,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, phase
  );
  modport slave (
    input  tick, ew_req, ped_req,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, phase
  );
endinterface

// File: rtl/intersection_sequencer.sv
// intersection_sequencer: NS-resting two-road signal sequencer with tick-timed dwells
// Define PED_WALK_EN to let ped_req request EW service and drive walk during EW green.
module intersection_sequencer #(
  parameter int MIN_GREEN = 8,
  parameter int EW_GREEN  = 4,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int CNT_W     = 4
) (
  input logic clk,
  input logic reset,
  intersection_sequencer_if.slave s
);
  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALL_RED_1 = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALL_RED_2 = 3'd5
  } state_t;
  state_t state_q, state_d, next;
  logic [CNT_W-1:0] cnt_q, cnt_d, last;
  logic pending_q, pending_d, legal, req, go;
  always_comb begin
    legal = 1'b1;
    last  = '0;
    next  = S_ALL_RED_2;
    case (state_q)
      S_NS_GREEN:  begin last = CNT_W'(MIN_GREEN - 1); next = S_NS_YELLOW; end
      S_NS_YELLOW: begin last = CNT_W'(YELLOW - 1);    next = S_ALL_RED_1; end
      S_ALL_RED_1: begin last = CNT_W'(ALL_RED - 1);   next = S_EW_GREEN;  end
      S_EW_GREEN:  begin last = CNT_W'(EW_GREEN - 1);  next = S_EW_YELLOW; end
      S_EW_YELLOW: begin last = CNT_W'(YELLOW - 1);    next = S_ALL_RED_2; end
      S_ALL_RED_2: begin last = CNT_W'(ALL_RED - 1);   next = S_NS_GREEN;  end
      default:     legal = 1'b0;
    endcase
  end
`ifdef PED_WALK_EN
  assign req    = s.ew_req | s.ped_req;
  assign s.walk = state_q == S_EW_GREEN;
`else
  logic unused_ped;
  assign unused_ped = s.ped_req;
  assign req        = s.ew_req;
  assign s.walk     = 1'b0;
`endif
  // NS green holds (counter saturated) until a request is latched
  assign go = !legal || (s.tick && cnt_q == last && (state_q != S_NS_GREEN || pending_q));
  always_comb begin
    state_d   = go ? next : state_q;
    cnt_d     = go ? '0 : (s.tick && cnt_q < last) ? cnt_q + 1'b1 : cnt_q;
    pending_d = (pending_q | (req & (state_q != S_EW_GREEN))) & ~(go & (state_q == S_ALL_RED_1));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_ALL_RED_2;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end
  assign s.phase     = state_q;
  assign s.ns_green  = state_q == S_NS_GREEN;
  assign s.ns_yellow = state_q == S_NS_YELLOW;
  assign s.ns_red    = !(s.ns_green || s.ns_yellow);
  assign s.ew_green  = state_q == S_EW_GREEN;
  assign s.ew_yellow = state_q == S_EW_YELLOW;
  assign s.ew_red    = !(s.ew_green || s.ew_yellow);
endmodule

// File: tb/tb_intersection_sequencer.sv
// tb_intersection_sequencer: vector tables with an expected-phase scoreboard, plus async-reset sequences
module tb_intersection_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  intersection_sequencer_if bus();
  intersection_sequencer dut (.clk(clk), .reset(reset), .s(bus));
  typedef struct {
    logic       tick;
    logic       ew;
    logic       ped;
    logic [2:0] ph;
  } vec_t;
  vec_t vecs[$];
  logic [2:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;
`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif
  function automatic logic [5:0] lamps(input logic [2:0] ph);
    case (ph)
      3'd0:    return 6'b001_100;
      3'd1:    return 6'b010_100;
      3'd3:    return 6'b100_001;
      3'd4:    return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction
  task automatic check(input logic [2:0] ph, input string name);
    logic [9:0] got, want;
    got  = {bus.phase, bus.ns_red, bus.ns_yellow, bus.ns_green,
            bus.ew_red, bus.ew_yellow, bus.ew_green, bus.walk};
    want = {ph, lamps(ph), PED && (ph == 3'd3)};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got phase/lamps/walk %b, want %b", name, got, want);
    end
  endtask
  task automatic add(input logic t, input logic e, input logic p, input logic [2:0] ph, input int n);
    repeat (n) vecs.push_back('{t, e, p, ph});
  endtask
  task automatic add4(input logic [2:0] ph, input int n);
    repeat (n) vecs.push_back('{(vecs.size() % 4) == 0, 1'b1, 1'b0, ph});
  endtask
  task automatic run(input string name);
    foreach (vecs[i]) begin
      bus.tick    = vecs[i].tick;
      bus.ew_req  = vecs[i].ew;
      bus.ped_req = vecs[i].ped;
      sb.push_back(vecs[i].ph);
      @(posedge clk);
      #1;
      check(sb.pop_front(), $sformatf("%s[%0d]", name, i));
      @(negedge clk);
    end
    bus.tick = 1'b0; bus.ew_req = 1'b0; bus.ped_req = 1'b0;
    vecs.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    bus.tick = 1'b0; bus.ew_req = 1'b0; bus.ped_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check(3'd5, "reset_state");
  endtask
  task automatic async_reset(input string name);
    #2 reset = 1'b1;
    #1 check(3'd5, name);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    bus.tick = 1'b0; bus.ew_req = 1'b0; bus.ped_req = 1'b0;
    // idle: NS rests in green
    do_reset();
    add(1, 0, 0, 0, 50);
    run("idle");
    // single ew pulse: full cycle, then back to resting NS green
    do_reset();
    add(1, 0, 0, 0, 2); add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 5);
    add(1, 0, 0, 1, 2); add(1, 0, 0, 2, 1); add(1, 0, 0, 3, 4);
    add(1, 0, 0, 4, 2); add(1, 0, 0, 5, 1); add(1, 0, 0, 0, 10);
    run("ew_pulse");
    // tick every 4th cycle, request held
    do_reset();
    add4(0, 32); add4(1, 8); add4(2, 4); add4(3, 16);
    add4(4, 8); add4(5, 4); add4(0, 32); add4(1, 4);
    run("slow_tick");
    // pulse during EW_YELLOW is retained and re-serves after min green
    do_reset();
    add(1, 0, 0, 0, 2); add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 5);
    add(1, 0, 0, 1, 2); add(1, 0, 0, 2, 1); add(1, 0, 0, 3, 4);
    add(1, 0, 0, 4, 1); add(1, 1, 0, 4, 1); add(1, 0, 0, 5, 1);
    add(1, 0, 0, 0, 8); add(1, 0, 0, 1, 2); add(1, 0, 0, 2, 1);
    add(1, 0, 0, 3, 4); add(1, 0, 0, 4, 2); add(1, 0, 0, 5, 1);
    add(1, 0, 0, 0, 5);
    run("yellow_req");
    // pulse during EW_GREEN is masked
    do_reset();
    add(1, 0, 0, 0, 2); add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 5);
    add(1, 0, 0, 1, 2); add(1, 0, 0, 2, 1); add(1, 0, 0, 3, 2);
    add(1, 1, 0, 3, 1); add(1, 0, 0, 3, 1); add(1, 0, 0, 4, 2);
    add(1, 0, 0, 5, 1); add(1, 0, 0, 0, 12);
    run("green_req");
    // async reset mid EW_GREEN, then normal resume
    do_reset();
    add(1, 0, 0, 0, 2); add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 5);
    add(1, 0, 0, 1, 2); add(1, 0, 0, 2, 1); add(1, 0, 0, 3, 2);
    run("pre_reset");
    async_reset("async_reset_ew_green");
    add(1, 0, 0, 0, 20);
    run("post_reset");
    // async reset discards a latched request
    do_reset();
    add(1, 0, 0, 0, 2); add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 2);
    run("pre_discard");
    async_reset("async_reset_ns_green");
    add(1, 0, 0, 0, 20);
    run("discard");
    // pedestrian request only
    do_reset();
`ifdef PED_WALK_EN
    add(1, 0, 0, 0, 2); add(1, 0, 1, 0, 1); add(1, 0, 0, 0, 5);
    add(1, 0, 0, 1, 2); add(1, 0, 0, 2, 1); add(1, 0, 0, 3, 4);
    add(1, 0, 0, 4, 2); add(1, 0, 0, 5, 1); add(1, 0, 0, 0, 10);
`else
    add(1, 0, 0, 0, 2); add(1, 0, 1, 0, 1); add(1, 0, 0, 0, 25);
`endif
    run("ped_pulse");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
